// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared constants and types for the Ethernet MAC receive path.
//   ETH_PREAMBLE / ETH_SFD : preamble and start-of-frame delimiter bytes
//   MIN_LEN_DEFAULT        : shortest legal frame, bytes after SFD incl. FCS
//   MAX_LEN_DEFAULT        : longest legal frame, bytes after SFD incl. FCS
//   rx_state_t             : receive framer FSM states
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam logic [7:0] ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0] ETH_SFD         = 8'hD5;
    localparam int         MIN_LEN_DEFAULT = 64;
    localparam int         MAX_LEN_DEFAULT = 1518;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/mac_rx_framer.sv
// ---------------------------------------------------------------------------
// mac_rx_framer
// Strips preamble/SFD from the RGMII receive byte stream and presents the
// frame (destination MAC through FCS) as a valid/last stream, flagging bad
// frames on the last beat and pulsing per-frame statistics.
//
// Ports
//   clk            in   receive clock (RGMII RX clock domain)
//   rst            in   synchronous active-high reset
//   rx_data[7:0]   in   received byte
//   rx_valid       in   RX_DV
//   rx_error       in   RX_ER
//   m_data[7:0]    out  frame byte
//   m_valid        out  m_data valid
//   m_last         out  last byte of frame
//   m_user         out  frame bad (qualified by m_last)
//   stat_frame_ok  out  pulse: good frame completed
//   stat_frame_bad out  pulse: bad frame completed
//   stat_len[10:0] out  byte count of last completed frame
// ---------------------------------------------------------------------------
module mac_rx_framer
    import mac_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_user,
    output logic        stat_frame_ok,
    output logic        stat_frame_bad,
    output logic [10:0] stat_len
);

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    rx_state_t   state;

    // One-byte hold stage: a byte is only released once we know whether it
    // is the last one, which is what lets m_last sit on the final byte.
    logic [7:0]  hold_data_p0;
    logic        hold_vld_p0;
    logic [10:0] len_p0;
    logic        err_p0;

    // Length counter saturates instead of wrapping on oversize frames.
    function automatic logic [10:0] len_sat_inc(input logic [10:0] len);
        return (len == 11'h7FF) ? len : len + 11'd1;
    endfunction

    // An empty frame (SFD followed directly by end of frame) is bad too.
    function automatic logic frame_is_bad(input logic        err,
                                          input logic [10:0] len,
                                          input logic        has_byte);
        return err || (len < MIN_LEN_W) || !has_byte;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_DROP;
            hold_data_p0   <= '0;
            hold_vld_p0    <= 1'b0;
            len_p0         <= '0;
            err_p0         <= 1'b0;
            m_data         <= '0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_user         <= 1'b0;
            stat_frame_ok  <= 1'b0;
            stat_frame_bad <= 1'b0;
            stat_len       <= '0;
        end else begin
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_user         <= 1'b0;
            stat_frame_ok  <= 1'b0;
            stat_frame_bad <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        state <= (rx_data == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                    end
                end

                ST_PREAMBLE: begin
                    if (!rx_valid) begin
                        state <= ST_IDLE;
                    end else if (rx_data == ETH_SFD) begin
                        state       <= ST_PAYLOAD;
                        len_p0      <= '0;
                        err_p0      <= 1'b0;
                        hold_vld_p0 <= 1'b0;
                    end else if (rx_data != ETH_PREAMBLE) begin
                        state <= ST_DROP;
                    end
                end

                ST_PAYLOAD: begin
                    if (rx_valid && (len_p0 == MAX_LEN_W)) begin
                        // Oversize: close the frame on the held byte, discard
                        // the rest until the line goes idle.
                        m_data         <= hold_data_p0;
                        m_valid        <= hold_vld_p0;
                        m_last         <= hold_vld_p0;
                        m_user         <= hold_vld_p0;
                        stat_frame_bad <= 1'b1;
                        stat_len       <= len_p0;
                        hold_vld_p0    <= 1'b0;
                        state          <= ST_DROP;
                    end else if (rx_valid) begin
                        hold_data_p0 <= rx_data;
                        hold_vld_p0  <= 1'b1;
                        len_p0       <= len_sat_inc(len_p0);
                        if (rx_error) begin
                            err_p0 <= 1'b1;
                        end
                        if (hold_vld_p0) begin
                            m_data  <= hold_data_p0;
                            m_valid <= 1'b1;
                        end
                    end else begin
                        // End of frame: flush the held byte as the last beat.
                        m_data         <= hold_data_p0;
                        m_valid        <= hold_vld_p0;
                        m_last         <= hold_vld_p0;
                        m_user         <= hold_vld_p0 &&
                                          frame_is_bad(err_p0, len_p0, hold_vld_p0);
                        stat_frame_ok  <= !frame_is_bad(err_p0, len_p0, hold_vld_p0);
                        stat_frame_bad <= frame_is_bad(err_p0, len_p0, hold_vld_p0);
                        stat_len       <= len_p0;
                        hold_vld_p0    <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!rx_valid) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_DROP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_mac_rx_framer
// Table-driven frame vectors plus hand-written corner sequences for the
// receive framer. Expected beats and stat pulses are queued when stimulus is
// driven and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mac_rx_framer;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_user;
    logic        stat_frame_ok;
    logic        stat_frame_bad;
    logic [10:0] stat_len;

    mac_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_error       (rx_error),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_user         (m_user),
        .stat_frame_ok  (stat_frame_ok),
        .stat_frame_bad (stat_frame_bad),
        .stat_len       (stat_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lead;       // 0: 7x55+D5, 1: 0x12 start, 2: 55,55,33
        int n;          // bytes driven after the lead-in
        int err_at;     // byte index with rx_error=1, -1 for none
        int exp_beats;
        bit exp_user;
        bit exp_ok;
        int exp_len;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic        ok;
        logic        bad;
        logic [10:0] len;
        logic        with_last;
    } stat_t;

    beat_t exp_q[$];
    stat_t stat_q[$];
    vec_t  vecs[12];

    int n_chk = 0;
    int n_err = 0;
    int beat_cnt;
    int stat_cnt;
    int last_len = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare whatever the DUT shows this cycle against the scoreboard.
    task automatic monitor();
        beat_t b;
        stat_t s;
        if (m_valid) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_beat: got data %0h, none expected", m_data);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", int'(m_data), int'(b.data));
                check("beat_last", int'(m_last), int'(b.last));
                if (b.last) check("beat_user", int'(m_user), int'(b.user));
            end
        end
        if (stat_frame_ok || stat_frame_bad) begin
            stat_cnt++;
            if (stat_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_stat: got ok=%0d bad=%0d, none expected",
                         stat_frame_ok, stat_frame_bad);
            end else begin
                s = stat_q.pop_front();
                check("stat_ok", int'(stat_frame_ok), int'(s.ok));
                check("stat_bad", int'(stat_frame_bad), int'(s.bad));
                check("stat_len", int'(stat_len), int'(s.len));
                check("stat_with_last", int'(m_last), int'(s.with_last));
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e);
        rx_valid = v;
        rx_data  = d;
        rx_error = e;
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic push_beats(input int cnt, input bit with_last, input bit user);
        beat_t b;
        for (int i = 0; i < cnt; i++) begin
            b.data = 8'(i);
            b.last = with_last && (i == cnt - 1);
            b.user = user;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_lead(input int lead);
        case (lead)
            0: begin
                for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0);
                step(1'b1, 8'hD5, 1'b0);
            end
            1: step(1'b1, 8'h12, 1'b0);
            default: begin
                step(1'b1, 8'h55, 1'b0);
                step(1'b1, 8'h55, 1'b0);
                step(1'b1, 8'h33, 1'b0);
            end
        endcase
    endtask

    task automatic send_frame(input vec_t v);
        stat_t s;
        beat_cnt = 0;
        stat_cnt = 0;
        push_beats(v.exp_beats, 1'b1, v.exp_user);
        if (v.lead == 0) begin
            s.ok        = v.exp_ok;
            s.bad       = !v.exp_ok;
            s.len       = 11'(v.exp_len);
            s.with_last = (v.exp_beats > 0);
            stat_q.push_back(s);
            last_len    = v.exp_len;
        end
        drive_lead(v.lead);
        for (int i = 0; i < v.n; i++) step(1'b1, 8'(i), 1'(i == v.err_at));
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check("frame_beats", beat_cnt, v.exp_beats);
        check("frame_stats", stat_cnt, (v.lead == 0) ? 1 : 0);
        check("stat_len_hold", int'(stat_len), last_len);
    endtask

    initial begin
        //          lead  n    err beats user ok  len
        vecs[0]  = '{0,   64,  -1, 64,   0,   1,  64};
        vecs[1]  = '{0,   64,  10, 64,   1,   0,  64};
        vecs[2]  = '{0,   20,  -1, 20,   1,   0,  20};
        vecs[3]  = '{0, 1600,  -1, 1518, 1,   0,  1518};
        vecs[4]  = '{1,   10,  -1, 0,    0,   0,  0};
        vecs[5]  = '{0,   64,  -1, 64,   0,   1,  64};
        vecs[6]  = '{2,   10,  -1, 0,    0,   0,  0};
        vecs[7]  = '{0,   65,  -1, 65,   0,   1,  65};
        vecs[8]  = '{0,    0,  -1, 0,    1,   0,  0};
        vecs[9]  = '{0, 1518,  -1, 1518, 0,   1,  1518};
        vecs[10] = '{0,   63,  -1, 63,   1,   0,  63};
        vecs[11] = '{0, 1519,  -1, 1518, 1,   0,  1518};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        beat_cnt = 0;
        stat_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_m_user", int'(m_user), 0);
        check("rst_stat_ok", int'(stat_frame_ok), 0);
        check("rst_stat_bad", int'(stat_frame_bad), 0);
        check("rst_stat_len", int'(stat_len), 0);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 12; k++) send_frame(vecs[k]);

        // Reset while byte 30 is on the line: bytes 0..28 are already out,
        // byte 29 is lost in the hold register, no last beat, no stat.
        beat_cnt = 0;
        stat_cnt = 0;
        push_beats(29, 1'b0, 1'b0);
        drive_lead(0);
        for (int i = 0; i < 30; i++) step(1'b1, 8'(i), 1'b0);
        rst = 1'b1;
        step(1'b1, 8'd30, 1'b0);
        step(1'b1, 8'd31, 1'b0);
        rst = 1'b0;
        for (int i = 32; i < 40; i++) step(1'b1, 8'(i), 1'b0);
        check("rst_release_len", int'(stat_len), 0);
        last_len = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check("rst_frame_beats", beat_cnt, 29);
        check("rst_frame_stats", stat_cnt, 0);
        send_frame(vecs[0]);

        check("beats_left", exp_q.size(), 0);
        check("stats_left", stat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_rx_framer.md
MAC_RX_FRAMER -- requirements
Module: mac_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum legal frame length in bytes after SFD, FCS included.
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  receive clock, the buffered RGMII RX clock
- rst  in  1  synchronous active-high reset
REQ-004 SHALL have the following data and status ports:
- rx_data  in  8  received byte, registered upstream
- rx_valid  in  1  RX_DV for rx_data
- rx_error  in  1  RX_ER for rx_data
- m_data  out  8  payload byte (destination MAC onward, FCS included)
- m_valid  out  1  m_data is valid
- m_last  out  1  last byte of the frame
- m_user  out  1  frame is bad; meaningful only when m_last=1
- stat_frame_ok  out  1  one-cycle pulse, good frame completed
- stat_frame_bad  out  1  one-cycle pulse, bad frame completed
- stat_len  out  11  byte count of the last completed frame

Function
REQ-005 SHALL implement states IDLE, PREAMBLE, PAYLOAD and DROP.
REQ-006 In IDLE, SHALL act on each clock edge as follows:
- rx_valid=1 and rx_data=0x55: go to PREAMBLE
- rx_valid=1 and any other byte: go to DROP
- rx_valid=0: stay in IDLE
REQ-007 In PREAMBLE, SHALL act on each clock edge as follows:
- 0x55 with rx_valid=1: stay
- 0xD5 with rx_valid=1: go to PAYLOAD and clear the length counter and error flag
- any other valid byte: go to DROP
- rx_valid=0: go to IDLE
- No output and no stat pulse in any of these cases.
REQ-008 In DROP, SHALL ignore input and go to IDLE on the first edge that samples rx_valid=0.
REQ-009 In PAYLOAD, each byte sampled with rx_valid=1 SHALL be loaded into a one-byte hold register and increment an 11-bit length counter that saturates at 2047.
REQ-010 If the hold register is already full when a new byte is loaded, the held byte SHALL be presented on the next cycle with m_valid=1 and m_last=0.
REQ-011 When rx_valid=0 is sampled in PAYLOAD, the held byte SHALL be presented on the next cycle with m_valid=1 and m_last=1, and the FSM SHALL go to IDLE.
REQ-012 Latency: byte i SHALL appear on m_data one cycle after the edge that samples byte i+1, or one cycle after the edge that samples the end of frame.
REQ-013 m_valid SHALL never be high on two cycles for the same byte; there is no backpressure input.
REQ-014 rx_error=1 with rx_valid=1 in PAYLOAD SHALL set a sticky error flag; reception of the frame SHALL continue.
REQ-015 On the m_last cycle, m_user SHALL be 1 if any of the following holds, otherwise 0:
- the error flag is set
- length < MIN_LEN
- the frame was truncated per REQ-016
REQ-016 If a valid byte arrives while length = MAX_LEN:
- the held byte SHALL be emitted with m_last=1 and m_user=1
- the new byte SHALL be discarded
- the FSM SHALL go to DROP
REQ-017 If rx_valid falls in PAYLOAD with the hold register empty (SFD then immediate end):
- no m_valid SHALL be produced
- stat_frame_bad SHALL pulse one cycle later with stat_len=0
REQ-018 stat_frame_ok or stat_frame_bad SHALL pulse in the same cycle as m_last; exactly one of them SHALL pulse per frame that entered PAYLOAD.
REQ-019 stat_len SHALL update in the same cycle as the stat pulse and hold its value until the next frame ends.
REQ-020 Frames aborted in IDLE, PREAMBLE or DROP SHALL produce no stat pulse.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 On rst=1, the following SHALL be cleared:
- m_data=0, m_valid=0, m_last=0, m_user=0
- stat_frame_ok=0, stat_frame_bad=0, stat_len=0
- hold register empty, length counter 0, error flag 0
REQ-023 On rst=1, the state SHALL be DROP, so that a frame already in progress when reset is released is discarded up to its first rx_valid=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no m_last and no stat pulse.

Structure
REQ-025 Package mac_pkg SHALL hold the following:
- ETH_PREAMBLE=8'h55
- ETH_SFD=8'hD5
- the default MIN_LEN and MAX_LEN values
- the FSM state enum
REQ-026 SHALL be a single module with no sub-modules; it is instantiated directly after the RGMII DDR receiver on its output clock.

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- 7x0x55, 0xD5, then 64 bytes 0x00..0x3F -> 64 m_valid beats, m_last on 0x3F, m_user=0, stat_frame_ok, stat_len=64.
- Same frame with rx_error=1 on byte 10 -> 64 beats, m_user=1, stat_frame_bad, stat_len=64.
- Preamble+SFD, then 20 bytes -> 20 beats, m_user=1, stat_frame_bad, stat_len=20.
- Preamble+SFD, then 1600 bytes with MAX_LEN=1518 -> exactly 1518 beats, m_user=1 on the last, stat_len=1518; remaining bytes ignored; next frame received normally.
- Frame starting 0x12 or 0x55,0x55,0x33 -> no output and no stat pulse; a following legal frame is received.
- rst pulsed at byte 30 of a frame, then released with rx_valid=1 -> no m_valid until a new frame after rx_valid=0; that frame is received with stat_frame_ok.
